// File: rtl/mux_varredura_ctrl.sv
// Loopback scan controller for the 4:1 mux: drives D, steps S with DWELL
// cycles per position, rebuilds the word from Y and flags any difference.
module mux_varredura_ctrl #(
    parameter int unsigned DWELL = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [3:0] D,
    output logic [1:0] S,
    input  logic       Y,
    output logic       busy,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO,
        VARRE,
        FIM
    } state_t;

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    state_t     state, state_n;
    logic [3:0] d_n;
    logic [1:0] s_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] captura, cap_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OCIOSO;
            D       <= 4'd0;
            S       <= 2'd0;
            cnt     <= 8'd0;
            captura <= 4'd0;
        end else begin
            state   <= state_n;
            D       <= d_n;
            S       <= s_n;
            cnt     <= cnt_n;
            captura <= cap_n;
        end
    end

    always_comb begin
        state_n = state;
        d_n     = D;
        s_n     = S;
        cnt_n   = cnt;
        cap_n   = captura;
        unique case (state)
            OCIOSO: begin
                if (in_valid) begin
                    d_n     = in_data;
                    s_n     = 2'd0;
                    cnt_n   = 8'd0;
                    cap_n   = 4'd0;
                    state_n = VARRE;
                end
            end
            VARRE: begin
                // Y is sampled in the last cycle of each dwell window
                if (cnt == LAST) begin
                    cap_n[S] = Y;
                    cnt_n    = 8'd0;
                    if (S == 2'd3) begin
                        state_n = FIM;
                    end else begin
                        s_n = S + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            FIM: begin
                state_n = OCIOSO;
            end
            default: begin
                state_n = OCIOSO;
            end
        endcase
    end

    assign in_ready  = (state == OCIOSO) && !rst;
    assign busy      = (state != OCIOSO);
    assign out_valid = (state == FIM);
    assign out_data  = captura;
    assign erro      = (state == FIM) && (captura != D);

endmodule

// File: tb/tb_mux_varredura_ctrl.sv
// Bench for mux_varredura_ctrl: DWELL=20 and DWELL=1 instances, each
// looped back through a behavioural mux with injectable faults on Y.
module tb_mux_varredura_ctrl;

    localparam int DW = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] d;
    logic [1:0] s;
    logic       y;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_data;
    logic       erro;

    logic       in_valid_b;
    logic [3:0] in_data_b;
    logic       in_ready_b;
    logic [3:0] d_b;
    logic [1:0] s_b;
    logic       y_b;
    logic       busy_b;
    logic       out_valid_b;
    logic [3:0] out_data_b;
    logic       erro_b;

    logic       force0 = 1'b0;
    logic [3:0] flip = 4'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Mux model: Y = D[S], optionally stuck at 0 or inverted per position
    assign y   = force0 ? 1'b0 : (d[s] ^ flip[s]);
    assign y_b = d_b[s_b];

    mux_varredura_ctrl #(.DWELL(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .D(d), .S(s), .Y(y), .busy(busy),
        .out_valid(out_valid), .out_data(out_data), .erro(erro)
    );

    mux_varredura_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .D(d_b), .S(s_b), .Y(y_b), .busy(busy_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .erro(erro_b)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] w);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready got=%b want=1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
    endtask

    // Called right after the accepting edge; mode 0 = random noise on
    // in_valid, 1 = in_valid/1111 held while busy, 2 = next word queued.
    task automatic scan(input logic [3:0] w, input int mode,
                        input logic [3:0] nxt, input string name);
        logic [3:0] exp;
        logic       exp_err;
        exp     = force0 ? 4'd0 : (w ^ flip);
        exp_err = (exp != w);
        for (int j = 1; j <= 4 * DW + 2; j++) begin
            @(negedge clk);
            if (mode == 2) begin
                in_valid = 1'b1;
                in_data  = nxt;
            end else if (j == 4 * DW + 2) begin
                in_valid = 1'b0;
            end else if (mode == 1) begin
                in_valid = 1'b1;
                in_data  = 4'hf;
            end else begin
                in_valid = 1'($urandom);
                in_data  = 4'($urandom);
            end
            checks++;
            if (j <= 4 * DW) begin
                if (s !== 2'((j - 1) / DW) || d !== w || busy !== 1'b1 ||
                    in_ready !== 1'b0 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_scan j=%0d S=%0d D=%b busy=%b rdy=%b ov=%b want S=%0d D=%b busy=1 rdy=0 ov=0",
                             name, j, s, d, busy, in_ready, out_valid, (j - 1) / DW, w);
                end
            end else if (j == 4 * DW + 1) begin
                if (out_valid !== 1'b1 || out_data !== exp || erro !== exp_err ||
                    busy !== 1'b1 || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_result ov=%b data=%b erro=%b busy=%b rdy=%b want ov=1 data=%b erro=%b busy=1 rdy=0",
                             name, out_valid, out_data, erro, busy, in_ready, exp, exp_err);
                end
            end else begin
                if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || d !== w) begin
                    failures++;
                    $display("FAIL %s_idle ov=%b busy=%b rdy=%b D=%b want ov=0 busy=0 rdy=1 D=%b",
                             name, out_valid, busy, in_ready, d, w);
                end
            end
        end
        if (mode == 2) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 4'd0;
        in_valid_b = 1'b0;
        in_data_b = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || in_ready_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b/%b want=0/0", in_ready, in_ready_b);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (d !== 4'd0 || s !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== 4'd0 || erro !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state D=%b S=%0d busy=%b ov=%b data=%b erro=%b rdy=%b want 0 0 0 0 0000 0 1",
                     d, s, busy, out_valid, out_data, erro, in_ready);
        end
    endtask

    task automatic test_basic();
        force0 = 1'b0;
        flip = 4'd0;
        send(4'b0001);
        scan(4'b0001, 0, 4'd0, "basic");
    endtask

    task automatic test_stub_zero();
        force0 = 1'b1;
        send(4'b1011);
        scan(4'b1011, 0, 4'd0, "stub0");
        force0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        send(4'b1010);
        scan(4'b1010, 2, 4'b0101, "b2b_first");
        scan(4'b0101, 0, 4'd0, "b2b_second");
    endtask

    task automatic test_busy_ignore();
        send(4'b0011);
        scan(4'b0011, 1, 4'd0, "busy_ign");
        for (int j = 0; j < 4 * DW + 4; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || d !== 4'b0011) begin
                failures++;
                $display("FAIL busy_ign_after j=%0d ov=%b busy=%b D=%b want 0 0 0011",
                         j, out_valid, busy, d);
            end
        end
    endtask

    task automatic test_reset_mid();
        send(4'b1100);
        for (int j = 1; j <= 2 * DW + 3; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++;
        if (s !== 2'd2) begin
            failures++;
            $display("FAIL rstmid_pos S=%0d want=2", s);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ready got=%b want=0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (d !== 4'd0 || s !== 2'd0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state D=%b S=%0d busy=%b rdy=%b ov=%b want 0000 0 0 1 0",
                     d, s, busy, in_ready, out_valid);
        end
        for (int j = 0; j < 4 * DW + 5; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_quiet j=%0d ov=%b busy=%b want 0 0", j, out_valid, busy);
            end
        end
    endtask

    task automatic test_dwell1();
        logic [3:0] w;
        for (int k = 0; k < 6; k++) begin
            w = (k == 0) ? 4'b0110 : 4'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready_b !== 1'b1) begin
                failures++;
                $display("FAIL d1_ready got=%b want=1", in_ready_b);
            end
            in_valid_b = 1'b1;
            in_data_b  = w;
            @(posedge clk);
            for (int j = 1; j <= 6; j++) begin
                @(negedge clk);
                in_valid_b = (j < 6) ? 1'($urandom) : 1'b0;
                in_data_b  = 4'($urandom);
                checks++;
                if (j <= 4) begin
                    if (s_b !== 2'(j - 1) || busy_b !== 1'b1 || out_valid_b !== 1'b0 ||
                        d_b !== w) begin
                        failures++;
                        $display("FAIL d1_scan j=%0d S=%0d busy=%b ov=%b D=%b want S=%0d 1 0 %b",
                                 j, s_b, busy_b, out_valid_b, d_b, j - 1, w);
                    end
                end else if (j == 5) begin
                    if (out_valid_b !== 1'b1 || out_data_b !== w || erro_b !== 1'b0) begin
                        failures++;
                        $display("FAIL d1_result ov=%b data=%b erro=%b want 1 %b 0",
                                 out_valid_b, out_data_b, erro_b, w);
                    end
                end else begin
                    if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
                        failures++;
                        $display("FAIL d1_idle ov=%b rdy=%b want 0 1", out_valid_b, in_ready_b);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] w;
        for (int k = 0; k < 16; k++) begin
            w      = 4'($urandom);
            force0 = ($urandom_range(0, 7) == 0);
            flip   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            send(w);
            scan(w, 0, 4'd0, "rand");
        end
        force0 = 1'b0;
        flip   = 4'd0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stub_zero();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_dwell1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
